frame_fifo_sc: RTL and testbench

- Single-clock, store-and-forward frame FIFO for the L2 switch datapath. Parametrised in data width and depth.
- Adds frame-level commit/abort: a frame becomes visible to the reader only after its EOD word is written. Aborted or overflowed frames are rolled back and never reach the reader.
- Sits between the MAC receive logic and the switch forwarding engine when both run on the same clock.

---
 rtl/frame_fifo_sc_pkg.sv | 18 +
 rtl/sdp_ram_reg.sv | 29 ++
 rtl/frame_fifo_sc.sv | 108 ++++++++++
 tb/tb_frame_fifo_sc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/frame_fifo_sc_pkg.sv
// Shared constants and types for the L2 switch frame FIFO.
// Each FIFO word is {EOD, data}, so the EOD flag sits just above the data bits.
package pkg_l2sw;

    localparam int WA_DEF    = 11;
    localparam int WD_DEF    = 8;
    localparam int AFULL_DEF = 1800;

    typedef enum logic {
        WS_IDLE_OR_ACTIVE = 1'b0,
        WS_DISCARD        = 1'b1
    } wr_state_t;

    function automatic int eod_pos(input int wd);
        return wd;
    endfunction

endpackage

// File: rtl/sdp_ram_reg.sv
// Simple dual-port RAM with a registered read port.
// The storage array is not reset; only the read register is.
module sdp_ram_reg #(
    parameter int AW = 11,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register holds its value when no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_fifo_sc.sv
// Single-clock store-and-forward frame FIFO with commit/abort rollback.
// The read-data port is named rdata because "do" is a reserved word.
module frame_fifo_sc
    import pkg_l2sw::*;
#(
    parameter int WA        = WA_DEF,
    parameter int WD        = WD_DEF,
    parameter int AFULL_CNT = AFULL_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [WD-1:0] di,
    input  logic          we,
    input  logic          EOD_in,
    input  logic          abort_in,
    output logic [WD-1:0] rdata,
    output logic          EOD_out,
    input  logic          re,
    output logic          empty_flag,
    output logic          full_flag,
    output logic          afull_flag,
    output logic          frame_avail,
    output logic [WA:0]   frame_cnt,
    output logic          drop_pulse
);

    localparam int EOD_BIT = eod_pos(WD);

    logic [WA:0] wptr, cptr, rptr, occ;
    wr_state_t   state, state_nxt;
    logic        bad, drop_evt;
    logic        wr_acc, rd_acc, commit, rd_last;
    logic [WD:0] ram_q;
    logic        eod_shadow [0:(1<<WA)-1];

    assign empty_flag  = (rptr == cptr);
    assign full_flag   = (wptr == {~rptr[WA], rptr[WA-1:0]});
    assign occ         = wptr - rptr;
    assign afull_flag  = (32'(occ) >= AFULL_CNT);
    assign frame_avail = (frame_cnt != '0);

    assign wr_acc  = we & ~full_flag & ~abort_in & ~bad;
    assign rd_acc  = re & ~empty_flag;
    assign commit  = wr_acc & EOD_in;
    // Shadow copy of the EOD bits lets frame_cnt react in the read cycle itself.
    assign rd_last = rd_acc & eod_shadow[rptr[WA-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= WS_IDLE_OR_ACTIVE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort_in)
            state_nxt = WS_IDLE_OR_ACTIVE;
        else if (state == WS_DISCARD) begin
            if (we && EOD_in) state_nxt = WS_IDLE_OR_ACTIVE;
        end else if (we && full_flag && !EOD_in)
            state_nxt = WS_DISCARD;
    end

    // Overflow only counts as a drop once; the rest of that frame is swallowed silently.
    always_comb begin
        bad      = (state == WS_DISCARD);
        drop_evt = abort_in | (~bad & we & full_flag);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            cptr       <= '0;
            rptr       <= '0;
            frame_cnt  <= '0;
            drop_pulse <= 1'b0;
        end else begin
            if (drop_evt)    wptr <= cptr;
            else if (wr_acc) wptr <= wptr + 1'b1;
            if (commit)      cptr <= wptr + 1'b1;
            if (rd_acc)      rptr <= rptr + 1'b1;
            drop_pulse <= drop_evt;
            case ({commit, rd_last})
                2'b10:   frame_cnt <= frame_cnt + 1'b1;
                2'b01:   frame_cnt <= frame_cnt - 1'b1;
                default: frame_cnt <= frame_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) eod_shadow[wptr[WA-1:0]] <= EOD_in;
    end

    sdp_ram_reg #(.AW(WA), .DW(WD+1)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_acc),
        .waddr (wptr[WA-1:0]),
        .wdata ({EOD_in, di}),
        .re    (rd_acc),
        .raddr (rptr[WA-1:0]),
        .rdata (ram_q)
    );

    assign rdata   = ram_q[WD-1:0];
    assign EOD_out = ram_q[EOD_BIT];

endmodule

// File: tb/tb_frame_fifo_sc.sv
// Self-checking bench for frame_fifo_sc (WA=4) against a queue-based frame model.
module tb_frame_fifo_sc;

    localparam int WA    = 4;
    localparam int WD    = 8;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [WD-1:0] di;
    logic          we, EOD_in, abort_in, re;
    logic [WD-1:0] rdata;
    logic          EOD_out, empty_flag, full_flag, afull_flag, frame_avail, drop_pulse;
    logic [WA:0]   frame_cnt;

    int checks = 0;
    int failures = 0;

    // Model: committed words waiting to be read, words of the frame in progress.
    logic [8:0] cq[$];
    logic [8:0] pq[$];
    bit         discard;
    logic [7:0] exp_do;
    logic       exp_eod, exp_drop;

    int frames_wr, frames_rd, widx, cyc_cnt;
    bit w, r, prev_rd;
    logic [7:0] d;

    frame_fifo_sc #(.WA(WA), .WD(WD), .AFULL_CNT(AFULL)) dut (
        .clk(clk), .rst_n(rst_n), .di(di), .we(we), .EOD_in(EOD_in),
        .abort_in(abort_in), .rdata(rdata), .EOD_out(EOD_out), .re(re),
        .empty_flag(empty_flag), .full_flag(full_flag), .afull_flag(afull_flag),
        .frame_avail(frame_avail), .frame_cnt(frame_cnt), .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int occ_m();
        return cq.size() + pq.size();
    endfunction

    function automatic int fc_m();
        int n = 0;
        foreach (cq[i]) if (cq[i][8]) n++;
        return n;
    endfunction

    task automatic model_reset();
        cq.delete(); pq.delete();
        discard = 0; exp_do = '0; exp_eod = 0; exp_drop = 0;
    endtask

    task automatic model_update(input bit mw, input logic [7:0] md, input bit me,
                                input bit mab, input bit mr);
        bit full_m, empty_m;
        logic [8:0] x;
        full_m  = (occ_m() == DEPTH);
        empty_m = (cq.size() == 0);
        exp_drop = 0;
        if (mr && !empty_m) begin
            x = cq.pop_front();
            exp_do = x[7:0]; exp_eod = x[8];
        end
        if (mab) begin
            pq.delete(); discard = 0; exp_drop = 1;
        end else if (discard) begin
            if (mw && me) discard = 0;
        end else if (mw && full_m) begin
            pq.delete(); exp_drop = 1;
            if (!me) discard = 1;
        end else if (mw) begin
            pq.push_back({me, md});
            if (me) begin
                foreach (pq[i]) cq.push_back(pq[i]);
                pq.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("do",          32'(rdata),       32'(exp_do));
        chk("eod_out",     32'(EOD_out),     32'(exp_eod));
        chk("empty",       32'(empty_flag),  32'(cq.size() == 0));
        chk("full",        32'(full_flag),   32'(occ_m() == DEPTH));
        chk("afull",       32'(afull_flag),  32'(occ_m() >= AFULL));
        chk("frame_cnt",   32'(frame_cnt),   32'(fc_m()));
        chk("frame_avail", 32'(frame_avail), 32'(fc_m() != 0));
        chk("drop_pulse",  32'(drop_pulse),  32'(exp_drop));
    endtask

    task automatic step(input bit sw, input logic [7:0] sd, input bit se,
                        input bit sab, input bit sr);
        we = sw; di = sd; EOD_in = se; abort_in = sab; re = sr;
        @(posedge clk);
        model_update(sw, sd, se, sab, sr);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 0; we = 0; di = '0; EOD_in = 0; abort_in = 0; re = 0;
        model_reset();
        #12;
        check_all();
        rst_n = 1;

        // Three-word frame, then read it back.
        step(1, 8'hA1, 0, 0, 0);
        chk("a_empty_w1", 32'(empty_flag), 32'd1);
        step(1, 8'hA2, 0, 0, 0);
        step(1, 8'hA3, 1, 0, 0);
        chk("a_fcnt", 32'(frame_cnt), 32'd1);
        step(0, 8'h00, 0, 0, 1);
        chk("a_do1", 32'(rdata), 32'hA1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("a_do3", {23'd0, EOD_out, rdata}, 32'h1A3);
        step(0, 8'h00, 0, 0, 1);

        // Abort a partial frame, then a single-word frame.
        step(1, 8'h11, 0, 0, 0);
        step(1, 8'h12, 0, 0, 0);
        step(0, 8'h00, 0, 1, 0);
        chk("abort_drop", 32'(drop_pulse), 32'd1);
        step(1, 8'h77, 1, 0, 0);
        chk("solo_fcnt", 32'(frame_cnt), 32'd1);
        step(0, 8'h00, 0, 0, 1);
        chk("solo_do", 32'(rdata), 32'h77);
        step(0, 8'h00, 0, 0, 0);

        // Oversized 20-word frame is dropped; FIFO recovers.
        for (int i = 1; i <= 20; i++) begin
            step(1, 8'(8'h40 + i), (i == 20), 0, 0);
            if (i == 16) chk("big_full16", 32'(full_flag), 32'd1);
            if (i == 17) chk("big_drop17", 32'(drop_pulse), 32'd1);
        end
        step(0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), (i == 3), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 1);
        chk("post_big_last", 32'(rdata), 32'hC3);

        // Commit B while A's last word is read.
        step(1, 8'hD0, 0, 0, 0);
        step(1, 8'hD1, 1, 0, 0);
        step(1, 8'hE0, 0, 0, 1);
        step(1, 8'hE1, 1, 0, 1);
        chk("same_cyc_fcnt", 32'(frame_cnt), 32'd1);
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("b_last", {23'd0, EOD_out, rdata}, 32'h1E1);

        // Stream 100 five-word frames with concurrent random reads/writes.
        frames_wr = 0; frames_rd = 0; widx = 0; cyc_cnt = 0; prev_rd = 0;
        while ((frames_wr < 100 || cq.size() != 0) && cyc_cnt < 5000) begin
            w = (frames_wr < 100) && (occ_m() < DEPTH) && ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            prev_rd = r && (cq.size() != 0);
            step(w, d, w && (widx == 4), 0, r);
            if (prev_rd && EOD_out) frames_rd++;
            if (w) begin
                if (widx == 4) begin widx = 0; frames_wr++; end
                else widx++;
            end
            cyc_cnt++;
        end
        chk("stream_timeout", 32'(cyc_cnt < 5000), 32'd1);
        chk("stream_frames", 32'(frames_rd), 32'd100);

        // Asynchronous reset with two committed frames and a partial one.
        step(1, 8'h21, 0, 0, 0);
        step(1, 8'h22, 1, 0, 0);
        step(1, 8'h31, 1, 0, 0);
        step(1, 8'h41, 0, 0, 0);
        chk("pre_rst_fcnt", 32'(frame_cnt), 32'd2);
        we = 0; EOD_in = 0; re = 0;
        #1 rst_n = 0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #2 rst_n = 1;
        step(1, 8'h5A, 1, 0, 0);
        step(0, 8'h00, 0, 0, 1);
        chk("post_rst_do", {23'd0, EOD_out, rdata}, 32'h15A);
        step(0, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
